apb_mem_slave: RTL

//  Synthesizable APB (AMBA3 PREADY/PSLVERR) completer: a word-addressed memory behind one PSEL line.

---
 rtl/apb_mem_slave.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apb_mem_slave.sv
// APB completer with a word-addressed memory, programmable wait states and PSLVERR on range/alignment faults.
// Define APB_PSTRB_EN to add the PSTRB port and per-byte-lane writes.
module apb_mem_slave #(
   parameter int          P_DWIDTH    = 32,
   parameter int          P_STRB      = P_DWIDTH / 8,
   parameter int          P_DEPTH     = 16,
   parameter logic [31:0] P_ADDR_BASE = 32'h0,
   parameter int          P_WAIT      = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic [31:0]         PADDR,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [P_DWIDTH-1:0] PWDATA,
`ifdef APB_PSTRB_EN
   input  logic [P_STRB-1:0]   PSTRB,
`endif
   output logic [P_DWIDTH-1:0] PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int          IDX_W     = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam logic [31:0] LIMIT     = 32'(P_DEPTH * P_STRB);
   localparam logic [31:0] STRB32    = 32'(P_STRB);
   localparam logic [7:0]  WAIT_INIT = 8'(P_WAIT);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                err_q, err_d;
   logic                write_q, write_d;
   logic [P_DWIDTH-1:0] prdata_q, prdata_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;

   logic [P_DWIDTH-1:0] mem_q [P_DEPTH];

   logic [31:0]         off;
   logic                dec_err;
   logic [IDX_W-1:0]    dec_idx;
   logic                mem_we;
   logic [P_DWIDTH-1:0] wr_word;

   // Offset is unsigned, so addresses below the base wrap high and fail the range test.
   always_comb begin
      off     = PADDR - P_ADDR_BASE;
      dec_err = (off >= LIMIT) || ((off % STRB32) != 32'd0);
      dec_idx = IDX_W'(off / STRB32);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      err_d     = err_q;
      write_d   = write_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               idx_d    = dec_idx;
               err_d    = dec_err;
               write_d  = PWRITE;
               prdata_d = (!PWRITE && !dec_err) ? mem_q[dec_idx] : '0;
               if (P_WAIT == 0) begin
                  state_d   = S_ACCESS;
                  pready_d  = 1'b1;
                  pslverr_d = dec_err;
               end else begin
                  state_d   = S_WAIT;
                  cnt_d     = WAIT_INIT;
                  pready_d  = 1'b0;
                  pslverr_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               state_d   = S_IDLE;
               cnt_d     = 8'd0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end else if (cnt_q <= 8'd1) begin
               state_d   = S_ACCESS;
               cnt_d     = 8'd0;
               pready_d  = 1'b1;
               pslverr_d = err_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ACCESS: begin
            mem_we    = write_q && !err_q;
            state_d   = S_IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = 8'd0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
         end
      endcase
   end

   // Write data is taken from the access cycle; with strobes, unselected lanes keep the stored byte.
   always_comb begin
      wr_word = PWDATA;
`ifdef APB_PSTRB_EN
      wr_word = mem_q[idx_q];
      for (int b = 0; b < P_STRB; b++) begin
         if (PSTRB[b]) begin
            wr_word[8*b +: 8] = PWDATA[8*b +: 8];
         end
      end
`endif
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         write_q   <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         write_q   <= write_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Memory is not cleared by reset, but a reset edge blocks the pending write.
   always_ff @(posedge PCLK) begin
      if (!PRESET && mem_we) begin
         mem_q[idx_q] <= wr_word;
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule
